// File: rtl/cis_pkg.sv
// Shared types and sizing helpers for the group-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cis_pkg;

  // Sequencer states. The encodings are fixed here so that every file
  // sees the same values.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Number of GW-bit groups in an N-bit operand.
  function automatic int ng_of(input int n, input int gw);
    return n / gw;
  endfunction

  // Width of the group counter; at least one bit so a single-group
  // configuration still has a legal vector.
  function automatic int cw_of(input int n, input int gw);
    return ((n / gw) > 1) ? $clog2(n / gw) : 1;
  endfunction

endpackage

// File: rtl/cis_sub_group.sv
// GW-bit borrow-increment subtractor slice: diff = a - b - bin.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
//
// Ports:
//   a, b          : GW-bit minuend / subtrahend slice
//   bin           : borrow into bit 0 of the slice
//   diff          : GW-bit difference
//   bout          : borrow out of the slice MSB
//   msb_borrow_in : borrow into the slice MSB (used for signed overflow)
module cis_sub_group #(
  parameter int GW = 8
) (
  input  logic [GW-1:0] a,
  input  logic [GW-1:0] b,
  input  logic          bin,
  output logic [GW-1:0] diff,
  output logic          bout,
  output logic          msb_borrow_in
);

  logic [GW-1:0] g;     // bit generates a borrow: a=0, b=1
  logic [GW-1:0] p;     // bit passes an incoming borrow: a==b
  logic [GW-1:0] c;     // borrow into each bit
  logic          gacc;  // group generate over bits 0..i, assuming bin=0
  logic          pacc;  // group propagate over bits 0..i

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // The prefix chain is built with bin treated as 0; the real borrow-in
  // is folded in afterwards by one gray cell per bit (gacc | pacc&bin).
  // Accumulators are plain variables so the chain has no self-feedback
  // through a vector.
  always_comb begin
    c    = '0;
    gacc = 1'b0;
    pacc = 1'b1;
    for (int i = 0; i < GW; i++) begin
      c[i] = gacc | (pacc & bin);
      gacc = g[i] | (p[i] & gacc);
      pacc = p[i] & pacc;
    end
    bout = gacc | (pacc & bin);
  end

  assign diff          = a ^ b ^ c;
  assign msb_borrow_in = c[GW-1];

endmodule

// File: rtl/cis_seq_sub.sv
// Group-serial N-bit subtractor: diff = a - b - bin, with borrow-out and
// signed overflow, resolving GW bits per cycle through one shared slice.
// Latency: out_valid rises N/GW cycles after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE,
// so the minimum issue interval is N/GW + 2 cycles.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (a, b, bin)
//   out_valid, out_ready: result handshake (diff, bout, ovf)
module cis_seq_sub
  import cis_pkg::*;
#(
  parameter int N  = 64,
  parameter int GW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int NG = ng_of(N, GW);
  localparam int CW = cw_of(N, GW);

  generate
    if ((N % GW) != 0 || GW < 2) begin : g_bad_params
      $error("cis_seq_sub: N must be a multiple of GW and GW must be >= 2");
    end
  endgenerate

  state_t        state_q;
  state_t        state_d;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  diff_q;
  logic          borrow_q;   // borrow carried between groups
  logic          bout_q;
  logic          ovf_q;
  logic [CW-1:0] k_q;        // index of the group resolved this cycle

  logic [GW-1:0] grp_a;
  logic [GW-1:0] grp_b;
  logic [GW-1:0] grp_diff;
  logic          grp_bout;
  logic          grp_msb_bin;
  logic          last_grp;

  assign last_grp = (k_q == CW'(NG - 1));

  // Select the active group with constant-index slices so the mux stays
  // a plain one-hot compare on k.
  always_comb begin
    grp_a = '0;
    grp_b = '0;
    for (int gi = 0; gi < NG; gi++) begin
      if (k_q == CW'(gi)) begin
        grp_a = a_q[gi*GW +: GW];
        grp_b = b_q[gi*GW +: GW];
      end
    end
  end

  cis_sub_group #(
    .GW(GW)
  ) u_group (
    .a             (grp_a),
    .b             (grp_b),
    .bin           (borrow_q),
    .diff          (grp_diff),
    .bout          (grp_bout),
    .msb_borrow_in (grp_msb_bin)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_grp) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath. Operands are only written in IDLE, so in_valid during RUN or
  // DONE cannot disturb an operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      k_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            k_q      <= '0;
          end
        end
        RUN: begin
          for (int gi = 0; gi < NG; gi++) begin
            if (k_q == CW'(gi)) begin
              diff_q[gi*GW +: GW] <= grp_diff;
            end
          end
          borrow_q <= grp_bout;
          k_q      <= k_q + CW'(1);
          if (last_grp) begin
            bout_q <= grp_bout;
            // Signed overflow: borrow into the MSB differs from borrow out.
            ovf_q  <= grp_msb_bin ^ grp_bout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cis_seq_sub.sv
module tb_cis_seq_sub;

  localparam int N  = 64;
  localparam int GW = 8;
  localparam int NG = N / GW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  typedef struct packed {
    logic [N-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cis_seq_sub #(
    .N (N),
    .GW(GW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  function automatic exp_t mk(input logic [N-1:0] d, input logic bo, input logic ov);
    exp_t e;
    e.d  = d;
    e.bo = bo;
    e.ov = ov;
    return e;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compares every accepted result against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%h required=none", diff);
        end else begin
          e = expq.pop_front();
          check("res_diff", diff, e.d);
          check("res_bout", N'(bout), N'(e.bo));
          check("res_ovf", N'(ovf), N'(e.ov));
        end
      end
    end
  end

  // Issue one operand set, check latency and hold behaviour, then ack.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                        input logic tbin, input exp_t e,
                        input int hold, input bit pulse);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_issue", N'(in_ready), N'(1));
    a        = ta;
    b        = tb;
    bin      = tbin;
    in_valid = 1'b1;
    expq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = ~ta;
    b        = ~tb;
    bin      = ~tbin;
    n = 0;
    while (!out_valid && n < 50) begin
      if (pulse && n == 3) begin
        in_valid = 1'b1;
        a        = '1;
        b        = '0;
        bin      = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (pulse) check("run_in_ready", N'(in_ready), N'(0));
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("latency", N'(n), N'(NG));
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", N'(out_valid), N'(1));
      check("hold_in_ready", N'(in_ready), N'(0));
      check("hold_diff", diff, e.d);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after_ack_valid", N'(out_valid), N'(0));
    check("after_ack_in_ready", N'(in_ready), N'(1));
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_out_valid", N'(out_valid), N'(0));
    check("rst_diff", diff, '0);
    check("rst_bout", N'(bout), N'(0));
    check("rst_ovf", N'(ovf), N'(0));
    rst_n = 1'b1;

    // Basic subtract, result held 5 cycles, stray in_valid during RUN.
    run_op(64'd5, 64'd3, 1'b0, mk(64'd2, 1'b0, 1'b0), 5, 1'b1);
    // Borrow ripples through every group.
    run_op(64'd0, 64'd1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0), 0, 1'b0);
    // Borrow-in consumed across the group 0/1 boundary.
    run_op(64'h0000_0000_0000_0100, 64'd0, 1'b1, mk(64'h0000_0000_0000_00FF, 1'b0, 1'b0), 1, 1'b0);
    // Most negative minus one: signed overflow.
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1), 0, 1'b0);
    // Most positive minus -1: signed overflow and unsigned borrow.
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           mk(64'h8000_0000_0000_0000, 1'b1, 1'b1), 0, 1'b0);
    // Equal operands with borrow-in.
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
           mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0), 0, 1'b0);
    // Equal operands, no borrow-in.
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0,
           mk(64'd0, 1'b0, 1'b0), 2, 1'b0);

    // Reset in the middle of RUN, while group 3 is being resolved.
    a        = '1;
    b        = '0;
    bin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", N'(out_valid), N'(0));
    check("midrst_in_ready", N'(in_ready), N'(1));
    check("midrst_diff", diff, '0);
    check("midrst_bout", N'(bout), N'(0));
    check("midrst_ovf", N'(ovf), N'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Accepted on the first edge after release; latency check also shows
    // the discarded operation produces nothing earlier.
    run_op(64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 1'b0,
           mk(64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0), 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", N'(expq.size()), N'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
